decode_operand_stage: RTL
=========================

Name: decode_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU top.
- Accepts 32-bit MIPS instructions over a valid/ready handshake and reads a 32-entry register file.
- Registers opcode, func_field, A and B for the ALU, plus destination info for write-back.
- Owns the register file and a busy-register scoreboard that stalls on RAW hazards against in-flight instructions.

Parameters:
- DATA_W, 32, operand/register width.
- REG_AW, 5, register address width (2**REG_AW entries).
- BYPASS_EN, 1, 1 = same-cycle write-back data forwarded to operand reads.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  32  MIPS instruction word.
- wb_en  in  1  register write-back strobe from downstream.
- wb_addr  in  REG_AW  write-back register.
- wb_data  in  DATA_W  write-back value.
- out_valid  out  1  ALU-side outputs valid.
- out_ready  in  1  downstream consumes outputs.
- opcode  out  6  instr[31:26].
- func_field  out  6  instr[5:0] for R-type, else 0.
- A  out  DATA_W  rs operand.
- B  out  DATA_W  rt operand or sign-extended immediate.
- dest  out  REG_AW  destination register.
- dest_wr  out  1  instruction writes dest.
- illegal  out  1  sticky: an unsupported opcode was dropped.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, opcode=0, func_field=0, A=0, B=0, dest=0, dest_wr=0, illegal=0.
  - All registers cleared to 0; scoreboard cleared.
  - in_ready goes low while rst_n is low.
  - An instruction held in the output register is discarded.
- Decode, per opcode:
  - 0x00 (R-type): A=R[rs], B=R[rt], func_field=instr[5:0], dest=rd, dest_wr=(rd!=0).
  - 0x23 lw, 0x08 addi: A=R[rs], B=sext(imm16), dest=rt, dest_wr=(rt!=0).
  - 0x2B sw: A=R[rs], B=sext(imm16), dest_wr=0.
  - 0x04 beq: A=R[rs], B=R[rt], dest_wr=0.
  - Any other opcode: instruction accepted and dropped, out_valid unchanged, illegal set to 1 (sticky).
  - func_field=0 for every non-R opcode.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write-back occurs on wb_en at the clock edge regardless of stall state.
- Bypass (BYPASS_EN=1): if wb_en, wb_addr!=0 and wb_addr matches rs/rt, the operand uses wb_data in the same cycle.
- Scoreboard:
  - busy[dest] set when an instruction with dest_wr=1 is accepted.
  - busy[wb_addr] cleared on wb_en.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard:
  - hazard=1 when a register the instruction uses (rs; rt for R-type/beq/sw) is nonzero and busy.
  - A register being cleared by wb_en this cycle counts as not busy when BYPASS_EN=1.
- Handshake:
  - in_ready = rst_n & !hazard & (!out_valid | out_ready).
  - Accept when in_valid & in_ready; latency 1 cycle (outputs valid on the next edge).
  - out_valid holds and outputs are stable while out_ready=0.
  - Back-to-back acceptance every cycle when out_ready=1 and there is no hazard.
  - Output register cleared to out_valid=0 when consumed and no new accept occurs.
- Sign-extension: B = {{(DATA_W-16){imm[15]}}, imm}; 0x8000 becomes 0xFFFF8000.

Decomposition:
- Shared package mips_isa_pkg:
  - Opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04, OP_ADDI=6'h08.
  - Func constants FN_ADD=6'h20, FN_AND=6'h24, FN_SLT=6'h2A, shared with the ALU control.
  - Instruction field-slice helpers.
- One sub-module: reg_file_2r1w.
  - Two asynchronous read ports, one synchronous write port.
  - R0 hardwired to 0 and write-through bypass.
  - Same reset behaviour as this stage.

Test Plan:
- Reset value:
  - Stimulus: after reset, wb R1=0x2222, R2=0x1111; issue add R3,R1,R2 (0x00221820).
  - Expected: next cycle out_valid=1, opcode=0x00, func_field=0x20, A=0x2222, B=0x1111, dest=3, dest_wr=1.
- lw immediate:
  - Stimulus: lw R4,-4(R1) (0x8C24FFFC).
  - Expected: opcode=0x23, func_field=0, A=0x2222, B=0xFFFFFFFC, dest=4.
- RAW stall:
  - Stimulus: issue add R3,R1,R2, then and R5,R3,R1 (0x00612824) with no write-back.
  - Expected: in_ready=0 while busy[3] is set. Drive wb_en R3=0x3333; that cycle in_ready=1, next cycle A=0x3333 (bypass).
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with in_valid=1.
  - Expected: outputs unchanged, in_ready=0, exactly one instruction accepted when out_ready returns to 1.
- Illegal opcode and R0 write:
  - Stimulus: instr 0xFC000000; wb_en to R0 with 0xDEAD.
  - Expected: illegal=1, out_valid unchanged; subsequent read of R0 returns 0.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while out_valid=1 and busy[3] is set.
  - Expected: out_valid=0 immediately (asynchronous), scoreboard clear, R1 reads 0 after release.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and instruction field helpers used by the decode stage
// and the ALU control.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_SLT = 6'h2A;

  function automatic logic [5:0] f_opcode(input logic [31:0] i);
    return i[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] i);
    return i[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] i);
    return i[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] i);
    return i[15:11];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] i);
    return i[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] i);
    return i[15:0];
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

  // rt is a source register only for these; lw/addi use it as destination.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Register file with two asynchronous read ports and one synchronous write port.
// R0 reads as zero; a same-cycle write can be forwarded to the read ports.
module reg_file_2r1w #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    if (raddr_a == '0) rdata_a = '0;
    else if (BYPASS_EN && we && (waddr == raddr_a)) rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs[raddr_b];
    if (raddr_b == '0) rdata_b = '0;
    else if (BYPASS_EN && we && (waddr == raddr_b)) rdata_b = wdata;
  end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode / operand-fetch stage: decodes MIPS words, reads operands, and stalls on
// RAW hazards against in-flight destinations tracked by a busy scoreboard.
module decode_operand_stage
  import mips_isa_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [5:0]        func_field,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [REG_AW-1:0] dest,
  output logic              dest_wr,
  output logic              illegal
);

  localparam int NREG = 1 << REG_AW;

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rdata_a, rdata_b, imm_sext;
  logic              legal, uses_rt, hazard, accept;
  logic [NREG-1:0]   busy, busy_eff, clear_mask, set_mask;
  logic [REG_AW-1:0] new_dest;
  logic              new_dest_wr;

  assign op       = f_opcode(instr);
  assign rs       = REG_AW'(f_rs(instr));
  assign rt       = REG_AW'(f_rt(instr));
  assign rd       = REG_AW'(f_rd(instr));
  assign legal    = op_legal(op);
  assign uses_rt  = op_uses_rt(op);
  assign imm_sext = {{(DATA_W-16){instr[15]}}, f_imm(instr)};

  reg_file_2r1w #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .BYPASS_EN(BYPASS_EN)
  ) u_rf (
    .clk(clk), .rst_n(rst_n),
    .we(wb_en), .waddr(wb_addr), .wdata(wb_data),
    .raddr_a(rs), .raddr_b(rt),
    .rdata_a(rdata_a), .rdata_b(rdata_b)
  );

  // A register retiring this cycle is forwarded, so it no longer blocks issue.
  assign clear_mask = wb_en ? (NREG'(1) << wb_addr) : '0;
  assign busy_eff   = BYPASS_EN ? (busy & ~clear_mask) : busy;

  assign hazard = legal && (((rs != '0) && busy_eff[rs]) ||
                            (uses_rt && (rt != '0) && busy_eff[rt]));

  always_comb begin
    new_dest = '0;
    if (op == OP_RTYPE) new_dest = rd;
    else if ((op == OP_LW) || (op == OP_ADDI)) new_dest = rt;
  end
  assign new_dest_wr = ((op == OP_RTYPE) || (op == OP_LW) || (op == OP_ADDI)) &&
                       (new_dest != '0);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // in_ready never depends on in_valid; out_valid/outputs hold until out_ready.
  assign in_ready = rst_n & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign set_mask = (accept && legal && new_dest_wr) ? (NREG'(1) << new_dest) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clear_mask) | set_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      opcode     <= '0;
      func_field <= '0;
      A          <= '0;
      B          <= '0;
      dest       <= '0;
      dest_wr    <= 1'b0;
      illegal    <= 1'b0;
    end else if (accept && legal) begin
      out_valid  <= 1'b1;
      opcode     <= op;
      func_field <= (op == OP_RTYPE) ? f_funct(instr) : 6'h00;
      A          <= rdata_a;
      B          <= (uses_rt && (op != OP_SW)) ? rdata_b : imm_sext;
      dest       <= new_dest;
      dest_wr    <= new_dest_wr;
    end else begin
      if (accept) illegal <= 1'b1;
      if (out_ready) out_valid <= 1'b0;
    end
  end

endmodule
